// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY bus controller: register addresses,
// controller states and the power-up register write table.
package pokey_pkg;

    localparam logic [3:0] ADDR_AUDC1  = 4'h1;
    localparam logic [3:0] ADDR_AUDC2  = 4'h3;
    localparam logic [3:0] ADDR_AUDC3  = 4'h5;
    localparam logic [3:0] ADDR_AUDC4  = 4'h7;
    localparam logic [3:0] ADDR_AUDCTL = 4'h8;
    localparam logic [3:0] ADDR_SKCTL  = 4'hF;

    localparam logic [2:0] LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        INIT_WR,
        SETTLE,
        IDLE,
        SECOND
    } state_t;

    // Step 0 holds the chips in reset; the last step releases them.
    function automatic logic [11:0] init_entry(input logic [2:0] step,
                                               input logic [7:0] audctl,
                                               input logic [7:0] skctl);
        logic [11:0] entry;
        case (step)
            3'd0:    entry = {ADDR_SKCTL, 8'h00};
            3'd1:    entry = {ADDR_AUDCTL, audctl};
            3'd2:    entry = {ADDR_AUDC1, 8'h00};
            3'd3:    entry = {ADDR_AUDC2, 8'h00};
            3'd4:    entry = {ADDR_AUDC3, 8'h00};
            3'd5:    entry = {ADDR_AUDC4, 8'h00};
            default: entry = {ADDR_SKCTL, skctl};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/pokey_bus_ctrl.sv
// CPU-to-POKEY bus controller: runs the init write sequence, then passes
// CPU accesses to one or both chips (chip 2 first) with registered returns.
module pokey_bus_ctrl
    import pokey_pkg::*;
#(
    parameter logic [7:0] INIT_AUDCTL   = 8'h00,
    parameter logic [7:0] INIT_SKCTL    = 8'h03,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [3:0] CPU_ADDR,
    input  logic [7:0] CPU_DIN,
    input  logic       CPU_RW_L,
    input  logic       CPU_CS1_L,
    input  logic       CPU_CS2_L,
    output logic       CPU_RDY,
    output logic [7:0] CPU_DOUT,
    output logic       CPU_DVALID,
    input  logic       REINIT,
    output logic [3:0] PK_ADDR,
    output logic [7:0] PK_DIN,
    output logic       PK_RW_L,
    output logic       PK1_CS_L,
    output logic       PK2_CS_L,
    input  logic [7:0] PK1_DOUT,
    input  logic [7:0] PK2_DOUT,
    output logic       INIT_BUSY,
    output logic       POKEY_ACTIVE
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] step;
    logic [3:0] settle_cnt;
    logic [3:0] hold_addr;
    logic [7:0] hold_din;
    logic       hold_rw_l;
    logic       rd1_pend;
    logic       rd2_pend;
    logic       reinit_pend;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state        <= INIT_WR;
            step         <= '0;
            settle_cnt   <= '0;
            PK_ADDR      <= '0;
            PK_DIN       <= '0;
            PK_RW_L      <= 1'b1;
            PK1_CS_L     <= 1'b1;
            PK2_CS_L     <= 1'b1;
            POKEY_ACTIVE <= 1'b0;
            CPU_DOUT     <= '0;
            CPU_DVALID   <= 1'b0;
            CPU_RDY      <= 1'b0;
            INIT_BUSY    <= 1'b1;
            hold_addr    <= '0;
            hold_din     <= '0;
            hold_rw_l    <= 1'b1;
            rd1_pend     <= 1'b0;
            rd2_pend     <= 1'b0;
            reinit_pend  <= 1'b0;
        end else begin
            CPU_DVALID   <= 1'b0;
            rd1_pend     <= 1'b0;
            rd2_pend     <= 1'b0;
            PK1_CS_L     <= 1'b1;
            PK2_CS_L     <= 1'b1;
            PK_RW_L      <= 1'b1;
            POKEY_ACTIVE <= 1'b0;

            // Read data returns one edge after the chip was selected.
            if (rd2_pend) begin
                CPU_DOUT   <= PK2_DOUT;
                CPU_DVALID <= 1'b1;
            end else if (rd1_pend) begin
                CPU_DOUT   <= PK1_DOUT;
                CPU_DVALID <= 1'b1;
            end

            case (state)
                INIT_WR: begin
                    {PK_ADDR, PK_DIN} <= init_entry(step, INIT_AUDCTL, INIT_SKCTL);
                    PK_RW_L      <= 1'b0;
                    PK1_CS_L     <= 1'b0;
                    PK2_CS_L     <= 1'b0;
                    POKEY_ACTIVE <= 1'b1;
                    if (step == 3'd0) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        step       <= 3'd1;
                    end else if (step == LAST_STEP) begin
                        state <= IDLE;
                        step  <= '0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= INIT_WR;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                IDLE: begin
                    // CPU_RDY is low only on the first IDLE cycle after init.
                    if (!CPU_RDY) begin
                        INIT_BUSY <= 1'b0;
                        CPU_RDY   <= 1'b1;
                    end else begin
                        if (!CPU_CS2_L) begin
                            PK_ADDR      <= CPU_ADDR;
                            PK_DIN       <= CPU_DIN;
                            PK_RW_L      <= CPU_RW_L;
                            PK2_CS_L     <= 1'b0;
                            POKEY_ACTIVE <= 1'b1;
                            rd2_pend     <= CPU_RW_L;
                            if (!CPU_CS1_L) begin
                                hold_addr <= CPU_ADDR;
                                hold_din  <= CPU_DIN;
                                hold_rw_l <= CPU_RW_L;
                                CPU_RDY   <= 1'b0;
                                state     <= SECOND;
                            end
                        end else if (!CPU_CS1_L) begin
                            PK_ADDR      <= CPU_ADDR;
                            PK_DIN       <= CPU_DIN;
                            PK_RW_L      <= CPU_RW_L;
                            PK1_CS_L     <= 1'b0;
                            POKEY_ACTIVE <= 1'b1;
                            rd1_pend     <= CPU_RW_L;
                        end
                        if (REINIT) begin
                            INIT_BUSY <= 1'b1;
                            CPU_RDY   <= 1'b0;
                            if (!CPU_CS1_L && !CPU_CS2_L) begin
                                reinit_pend <= 1'b1;
                            end else begin
                                state <= INIT_WR;
                            end
                        end
                    end
                end
                SECOND: begin
                    PK_ADDR      <= hold_addr;
                    PK_DIN       <= hold_din;
                    PK_RW_L      <= hold_rw_l;
                    PK1_CS_L     <= 1'b0;
                    POKEY_ACTIVE <= 1'b1;
                    rd1_pend     <= hold_rw_l;
                    reinit_pend  <= 1'b0;
                    if (reinit_pend || REINIT) begin
                        state     <= INIT_WR;
                        INIT_BUSY <= 1'b1;
                        CPU_RDY   <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        CPU_RDY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
